// File: rtl/ofdm_ifft_ctrl.sv
// Framing and configuration controller between the QAM mapper and the FFT core used as IFFT.
// Issues the core config word, generates input tlast, checks output framing.
module ofdm_ifft_ctrl #(
  parameter int unsigned DATA_W            = 16,
  parameter int unsigned CFG_W             = 24,
  parameter logic [CFG_W-1:0] CFG_DEFAULT  = 24'h308205,
  parameter int unsigned NFFT_LOG2_DEFAULT = 4,
  parameter int unsigned NFFT_LOG2_MAX     = 4,
  parameter int unsigned FRAME_W           = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CFG_W-1:0]      cfg_word,
  input  logic [4:0]            cfg_nfft_log2,
  input  logic                  cfg_update,
  input  logic [2*DATA_W-1:0]   s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [CFG_W-1:0]      core_cfg_tdata,
  output logic                  core_cfg_tvalid,
  input  logic                  core_cfg_tready,
  output logic [2*DATA_W-1:0]   core_s_tdata,
  output logic                  core_s_tvalid,
  output logic                  core_s_tlast,
  input  logic                  core_s_tready,
  input  logic [2*DATA_W-1:0]   core_m_tdata,
  input  logic                  core_m_tvalid,
  input  logic                  core_m_tlast,
  output logic                  core_m_tready,
  output logic [2*DATA_W-1:0]   m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [DATA_W-1:0]     m_real_ob,
  output logic [FRAME_W-1:0]    frame_cnt,
  output logic                  busy,
  output logic                  err_framing
);

  localparam int unsigned CNT_W = NFFT_LOG2_MAX;

  typedef enum logic {ST_CFG = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CFG_W-1:0]   cfg_reg, pend_cfg;
  logic [4:0]         nfft_act, pend_nfft, nfft_clamp;
  logic               pending;
  logic [CNT_W-1:0]   in_cnt, out_cnt, last_idx;
  logic               gate, apply_cfg, in_acc, out_acc, out_last;

  assign last_idx  = CNT_W'((32'd1 << nfft_act) - 32'd1);
  assign apply_cfg = (state == ST_RUN) && pending && (in_cnt == '0);

  // Clamp requested point size into the supported range
  always_comb begin
    nfft_clamp = cfg_nfft_log2;
    if (cfg_nfft_log2 < 5'd3)
      nfft_clamp = 5'd3;
    else if (cfg_nfft_log2 > 5'(NFFT_LOG2_MAX))
      nfft_clamp = 5'(NFFT_LOG2_MAX);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_CFG;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CFG:  if (core_cfg_tready) state_nxt = ST_RUN;
      ST_RUN:  if (apply_cfg)       state_nxt = ST_CFG;
      default: state_nxt = ST_CFG;
    endcase
  end

  always_comb begin
    core_cfg_tvalid = 1'b0;
    busy            = 1'b0;
    gate            = 1'b0;
    case (state)
      ST_CFG: begin
        core_cfg_tvalid = 1'b1;
        busy            = 1'b1;
      end
      ST_RUN:  gate = !(pending && (in_cnt == '0));
      default: gate = 1'b0;
    endcase
  end

  // Pending request capture; a same-cycle request survives the apply
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cfg_reg   <= CFG_DEFAULT;
      nfft_act  <= 5'(NFFT_LOG2_DEFAULT);
      pend_cfg  <= CFG_DEFAULT;
      pend_nfft <= 5'(NFFT_LOG2_DEFAULT);
      pending   <= 1'b0;
    end else begin
      if (apply_cfg) begin
        cfg_reg  <= pend_cfg;
        nfft_act <= pend_nfft;
        pending  <= 1'b0;
      end
      if (cfg_update) begin
        pend_cfg  <= cfg_word;
        pend_nfft <= nfft_clamp;
        pending   <= 1'b1;
      end
    end
  end

  assign core_cfg_tdata = cfg_reg;
  assign core_s_tdata   = s_tdata;
  assign core_s_tvalid  = s_tvalid & gate;
  assign s_tready       = core_s_tready & gate;
  assign core_s_tlast   = (in_cnt == last_idx);
  assign in_acc         = core_s_tvalid & core_s_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)      in_cnt <= '0;
    else if (in_acc) in_cnt <= core_s_tlast ? '0 : in_cnt + CNT_W'(1);
  end

  assign m_tdata       = core_m_tdata;
  assign m_tvalid      = core_m_tvalid;
  assign m_tlast       = core_m_tlast;
  assign core_m_tready = m_tready;
  assign m_real_ob     = {~core_m_tdata[2*DATA_W-1], core_m_tdata[2*DATA_W-2:DATA_W]};
  assign out_acc       = core_m_tvalid & m_tready;
  assign out_last      = (out_cnt == last_idx);

  // Output framing check; core tlast resynchronises the beat counter
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_cnt     <= '0;
      frame_cnt   <= '0;
      err_framing <= 1'b0;
    end else if (out_acc) begin
      if (core_m_tlast != out_last) err_framing <= 1'b1;
      if (core_m_tlast) begin
        out_cnt   <= '0;
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end else if (out_last) begin
        out_cnt <= '0;
      end else begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ofdm_ifft_ctrl.sv
// Scoreboard bench for ofdm_ifft_ctrl: directed stimulus pushes expectations,
// a negedge monitor pops them on every handshake.
module tb_ofdm_ifft_ctrl;

  logic        aclk = 1'b0;
  logic        areset;
  logic [23:0] cfg_word;
  logic [4:0]  cfg_nfft_log2;
  logic        cfg_update;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [23:0] core_cfg_tdata;
  logic        core_cfg_tvalid, core_cfg_tready;
  logic [31:0] core_s_tdata;
  logic        core_s_tvalid, core_s_tlast, core_s_tready;
  logic [31:0] core_m_tdata;
  logic        core_m_tvalid, core_m_tlast, core_m_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [15:0] m_real_ob;
  logic [15:0] frame_cnt;
  logic        busy, err_framing;

  int n_cmp = 0;
  int n_mis = 0;

  logic [32:0] in_q[$];
  logic [23:0] cfg_q[$];
  logic [16:0] out_q[$];

  ofdm_ifft_ctrl dut (
    .aclk(aclk), .areset(areset),
    .cfg_word(cfg_word), .cfg_nfft_log2(cfg_nfft_log2), .cfg_update(cfg_update),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .core_cfg_tdata(core_cfg_tdata), .core_cfg_tvalid(core_cfg_tvalid),
    .core_cfg_tready(core_cfg_tready),
    .core_s_tdata(core_s_tdata), .core_s_tvalid(core_s_tvalid),
    .core_s_tlast(core_s_tlast), .core_s_tready(core_s_tready),
    .core_m_tdata(core_m_tdata), .core_m_tvalid(core_m_tvalid),
    .core_m_tlast(core_m_tlast), .core_m_tready(core_m_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .m_real_ob(m_real_ob), .frame_cnt(frame_cnt), .busy(busy),
    .err_framing(err_framing)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    n_cmp++;
    n_mis++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pop and compare on every handshake
  always @(negedge aclk) begin
    logic [32:0] ei;
    logic [23:0] ec;
    logic [16:0] eo;
    if (!areset) begin
      if (core_cfg_tvalid && core_cfg_tready) begin
        if (cfg_q.size() == 0) fail_msg("cfg_unexpected");
        else begin
          ec = cfg_q.pop_front();
          check("cfg_tdata", 64'(core_cfg_tdata), 64'(ec));
        end
      end
      if (core_s_tvalid && core_s_tready) begin
        if (in_q.size() == 0) fail_msg("in_unexpected");
        else begin
          ei = in_q.pop_front();
          check("core_s_tdata", 64'(core_s_tdata), 64'(ei[32:1]));
          check("core_s_tlast", 64'(core_s_tlast), 64'(ei[0]));
        end
      end
      if (m_tvalid && m_tready) begin
        if (out_q.size() == 0) fail_msg("out_unexpected");
        else begin
          eo = out_q.pop_front();
          check("m_real_ob", 64'(m_real_ob), 64'(eo[16:1]));
          check("m_tlast", 64'(m_tlast), 64'(eo[0]));
        end
      end
    end
  end

  // Offer one input beat; entered and left just after a rising edge
  task automatic send_in(input logic [31:0] d, input logic lst);
    int t;
    t = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    in_q.push_back({d, lst});
    @(negedge aclk);
    while (!s_tready && t < 50) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      t++;
    end
    if (!s_tready) fail_msg("in_timeout");
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int period, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      send_in(base + 32'(i), (i % period) == (period - 1));
  endtask

  task automatic do_cfg();
    int t;
    t = 0;
    core_cfg_tready = 1'b1;
    @(negedge aclk);
    while (!core_cfg_tvalid && t < 20) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      t++;
    end
    if (!core_cfg_tvalid) fail_msg("cfg_timeout");
    @(posedge aclk); #1;
    core_cfg_tready = 1'b0;
  endtask

  task automatic send_out(input logic [15:0] re, input logic [15:0] exp_ob, input logic lst);
    core_m_tdata  = {re, 16'h1234};
    core_m_tlast  = lst;
    core_m_tvalid = 1'b1;
    out_q.push_back({exp_ob, lst});
    @(posedge aclk); #1;
    core_m_tvalid = 1'b0;
    core_m_tlast  = 1'b0;
  endtask

  logic [15:0] re_tab [3];
  logic [15:0] ob_tab [3];

  task automatic out_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++)
      send_out(re_tab[i % 3], ob_tab[i % 3], i == last_at);
  endtask

  initial begin
    int vld_cnt;
    re_tab[0] = 16'h8000; re_tab[1] = 16'h0000; re_tab[2] = 16'h7FFF;
    ob_tab[0] = 16'h0000; ob_tab[1] = 16'h8000; ob_tab[2] = 16'hFFFF;
    areset = 1'b1;
    cfg_word = '0; cfg_nfft_log2 = '0; cfg_update = 1'b0;
    s_tdata = '0; s_tvalid = 1'b1;
    core_cfg_tready = 1'b0; core_s_tready = 1'b1;
    core_m_tdata = '0; core_m_tvalid = 1'b0; core_m_tlast = 1'b0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    @(negedge aclk);
    check("rst_cfg_tvalid", 64'(core_cfg_tvalid), 64'd1);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_cfg_tdata", 64'(core_cfg_tdata), 64'h308205);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_core_s_tvalid", 64'(core_s_tvalid), 64'd0);
    check("rst_core_s_tlast", 64'(core_s_tlast), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_err", 64'(err_framing), 64'd0);
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    areset = 1'b0;
    cfg_q.push_back(24'h308205);

    // Config handshake held off 5 cycles
    vld_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (core_cfg_tvalid) vld_cnt++;
      @(posedge aclk); #1;
    end
    core_cfg_tready = 1'b1;
    @(negedge aclk);
    if (core_cfg_tvalid) vld_cnt++;
    check("hs_s_tready", 64'(s_tready), 64'd0);
    @(posedge aclk); #1;
    core_cfg_tready = 1'b0;
    @(negedge aclk);
    check("cfg_vld_cycles", 64'(vld_cnt), 64'd6);
    check("post_hs_cfg_tvalid", 64'(core_cfg_tvalid), 64'd0);
    check("post_hs_s_tready", 64'(s_tready), 64'd1);
    @(posedge aclk); #1;

    // 48 beats at N=16
    send_frame(48, 16, 32'hA000_0000);

    // Output framing and offset-binary real part
    m_tready = 1'b0;
    core_m_tvalid = 1'b1;
    @(negedge aclk);
    check("core_m_tready_low", 64'(core_m_tready), 64'd0);
    @(posedge aclk); #1;
    core_m_tvalid = 1'b0;
    m_tready = 1'b1;
    out_frame(16, 15);
    @(negedge aclk);
    check("frame_cnt_a", 64'(frame_cnt), 64'd1);
    check("err_a", 64'(err_framing), 64'd0);
    @(posedge aclk); #1;
    out_frame(10, -1);
    @(negedge aclk);
    check("err_before_early_last", 64'(err_framing), 64'd0);
    @(posedge aclk); #1;
    send_out(16'h7FFF, 16'hFFFF, 1'b1);
    @(negedge aclk);
    check("err_early_last", 64'(err_framing), 64'd1);
    check("frame_cnt_b", 64'(frame_cnt), 64'd2);
    @(posedge aclk); #1;
    out_frame(16, 15);
    @(negedge aclk);
    check("frame_cnt_c", 64'(frame_cnt), 64'd3);
    check("err_sticky", 64'(err_framing), 64'd1);
    @(posedge aclk); #1;

    // Reconfigure to N=8 mid-frame at beat 5
    send_frame(5, 16, 32'hB000_0000);
    cfg_update = 1'b1; cfg_word = 24'h123456; cfg_nfft_log2 = 5'd3;
    send_in(32'hB000_0005, 1'b0);
    cfg_update = 1'b0;
    for (int i = 6; i < 16; i++) send_in(32'hB000_0000 + 32'(i), i == 15);
    @(negedge aclk);
    check("gate_closed_s_tready", 64'(s_tready), 64'd0);
    check("gate_closed_cfg_tvalid", 64'(core_cfg_tvalid), 64'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("recfg_cfg_tvalid", 64'(core_cfg_tvalid), 64'd1);
    check("recfg_busy", 64'(busy), 64'd1);
    @(posedge aclk); #1;
    cfg_q.push_back(24'h123456);
    do_cfg();
    send_frame(16, 8, 32'hC000_0000);

    // Request at frame boundary, point size clamped from 9 to 4
    cfg_update = 1'b1; cfg_word = 24'h0A0B0C; cfg_nfft_log2 = 5'd9;
    @(negedge aclk);
    check("req_cycle_s_tready", 64'(s_tready), 64'd1);
    @(posedge aclk); #1;
    cfg_update = 1'b0;
    @(negedge aclk);
    check("idle_gate_drop", 64'(s_tready), 64'd0);
    @(posedge aclk); #1;
    @(negedge aclk);
    check("idle_cfg_tvalid", 64'(core_cfg_tvalid), 64'd1);
    @(posedge aclk); #1;
    cfg_q.push_back(24'h0A0B0C);
    do_cfg();
    send_frame(16, 16, 32'hD000_0000);

    // Reset at input beat 7
    send_frame(7, 16, 32'hE000_0000);
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_cfg_tvalid", 64'(core_cfg_tvalid), 64'd1);
    check("mid_rst_cfg_tdata", 64'(core_cfg_tdata), 64'h308205);
    check("mid_rst_s_tready", 64'(s_tready), 64'd0);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("mid_rst_err", 64'(err_framing), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    cfg_q.push_back(24'h308205);
    do_cfg();
    send_frame(16, 16, 32'hF000_0000);

    repeat (3) @(posedge aclk);
    #1;
    check("in_q_drained", 64'(in_q.size()), 64'd0);
    check("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
    check("out_q_drained", 64'(out_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ofdm_ifft_ctrl.md
# ofdm_ifft_ctrl

Parametrised framing and configuration controller placed between the QAM mapper and the Xilinx FFT core used as the OFDM IFFT. It issues the core configuration word after reset and on request at frame boundaries. It generates the input `tlast` from a runtime point size and passes data in both directions with zero latency. It checks output framing and presents an offset-binary real sample for the DAC path.

## Interface
Parameters:
- `DATA_W`, 16: bits per real/imag component; sample = {real, imag}, 2*DATA_W bits.
- `CFG_W`, 24: width of the core config word.
- `CFG_DEFAULT`, 24'h308205: config word sent after reset.
- `NFFT_LOG2_DEFAULT`, 4: point-size log2 after reset.
- `NFFT_LOG2_MAX`, 4: largest supported log2 point size (min is 3).
- `FRAME_W`, 16: width of `frame_cnt`.

Ports:
- `aclk`, in, 1: clock.
- `areset`, in, 1: asynchronous, active-high reset.
- `cfg_word`, in, CFG_W: new config payload, sampled on `cfg_update`.
- `cfg_nfft_log2`, in, 5: new point-size log2, sampled on `cfg_update`.
- `cfg_update`, in, 1: one-cycle reconfiguration request.
- `s_tdata`, in, 2*DATA_W: upstream sample.
- `s_tvalid`, in, 1: upstream valid.
- `s_tready`, out, 1: upstream ready.
- `core_cfg_tdata`, out, CFG_W: core config channel data.
- `core_cfg_tvalid`, out, 1: core config channel valid.
- `core_cfg_tready`, in, 1: core config channel ready.
- `core_s_tdata`, out, 2*DATA_W: core input data.
- `core_s_tvalid`, out, 1: core input valid.
- `core_s_tlast`, out, 1: core input last.
- `core_s_tready`, in, 1: core input ready.
- `core_m_tdata`, in, 2*DATA_W: core output data.
- `core_m_tvalid`, in, 1: core output valid.
- `core_m_tlast`, in, 1: core output last.
- `core_m_tready`, out, 1: core output ready.
- `m_tdata`, out, 2*DATA_W: downstream data.
- `m_tvalid`, out, 1: downstream valid.
- `m_tlast`, out, 1: downstream last.
- `m_tready`, in, 1: downstream ready.
- `m_real_ob`, out, DATA_W: offset-binary real part of `m_tdata`.
- `frame_cnt`, out, FRAME_W: count of completed output frames.
- `busy`, out, 1: high while in the CFG state.
- `err_framing`, out, 1: sticky output-framing error.

## Operation
- The FSM has two states, CFG and RUN.
  - While `areset` is high, the state is CFG, `cfg_reg`=CFG_DEFAULT, `nfft_act`=NFFT_LOG2_DEFAULT, and all counters, `pending` and `err_framing` are 0.
  - CFG: `core_cfg_tvalid`=1 and `core_cfg_tdata`=`cfg_reg`. The FSM moves to RUN on the cycle `core_cfg_tready` is high.
  - RUN: if `pending`=1 and `in_cnt`=0, the FSM moves to CFG and loads `cfg_reg` and `nfft_act` from the pending registers. `pending` clears on that transition.
- Reconfiguration request:
  - `cfg_update` latches `cfg_word` and the clamped `cfg_nfft_log2` (values <3 become 3; values >NFFT_LOG2_MAX become NFFT_LOG2_MAX) and sets `pending`.
  - A later request overwrites an unapplied one.
  - A request in the same cycle as the CFG->RUN transition is kept as a new pending request.
- Input path:
  - `core_s_tdata`=`s_tdata`.
  - `core_s_tvalid` = `s_tvalid` & gate, and `s_tready` = `core_s_tready` & gate.
  - gate = (state==RUN) & !(`pending` & `in_cnt`==0).
  - `in_cnt` increments on each accepted beat. `core_s_tlast` = (`in_cnt` == 2^`nfft_act`-1); `in_cnt` wraps to 0 after that beat.
  - A reconfiguration therefore never splits an input frame.
- Output path:
  - `m_tdata`/`m_tvalid`/`m_tlast` are wired directly from the core, and `core_m_tready`=`m_tready`.
  - `out_cnt` counts accepted beats.
  - `err_framing` sets if a beat is accepted with `core_m_tlast`=1 while `out_cnt` != N-1, or with `core_m_tlast`=0 while `out_cnt` = N-1 (N = 2^`nfft_act`).
  - On accepted `tlast`, `out_cnt` resets to 0 (resync) and `frame_cnt` increments, wrapping modulo 2^FRAME_W.
  - If `tlast` never arrives, `out_cnt` wraps at N-1.
  - `err_framing` clears only on reset.
- `m_real_ob` = `m_tdata[2*DATA_W-1:DATA_W]` with its MSB inverted, i.e. + 2^(DATA_W-1) modulo 2^DATA_W.
- `busy` = (state==CFG).

## Timing
- Reset values of outputs:
  - `core_cfg_tvalid`=1, `busy`=1, `core_cfg_tdata`=CFG_DEFAULT.
  - `s_tready`=0, `core_s_tvalid`=0, `core_s_tlast`=0.
  - `frame_cnt`=0, `err_framing`=0.
  - Pass-through outputs follow their inputs.
- Config handshake:
  - `core_cfg_tvalid` stays high until accepted and falls the cycle after `core_cfg_tready`.
  - `s_tready` can rise at the earliest one cycle after the handshake.
- Data paths have zero latency.
- Reconfiguration request:
  - When `in_cnt`=0, gate drops the cycle after `cfg_update`.
  - Otherwise gate drops the cycle after the `tlast` beat is accepted.
  - `core_cfg_tvalid` rises the following cycle.
- Asserting `areset` mid-frame aborts the frame immediately: counters clear and `cfg_tvalid` re-asserts with CFG_DEFAULT.

## Test plan
- Reset release with `core_cfg_tready` held 0 for 5 cycles, then 1 -> `core_cfg_tvalid` is high for 6 cycles with data 24'h308205; `s_tready` is first high 1 cycle after the handshake.
- 48 continuous input beats at N=16 with `core_s_tready`=1 -> `core_s_tlast` on beats 15, 31 and 47.
- `cfg_update` with `cfg_nfft_log2`=3 at input beat 5 -> beats 6..15 still accepted, `tlast` on beat 15, gate closes, config sent, next frame has `tlast` on its 8th beat.
- Core output `tlast` injected at beat 10 of a 16-point frame -> `err_framing`=1 permanently, `frame_cnt`+1, next frame counted from 0 without a new error.
- `m_tdata` real part 16'h8000 / 16'h0000 / 16'h7FFF -> `m_real_ob` = 16'h0000 / 16'h8000 / 16'hFFFF.
- `areset` pulse at input beat 7 -> `in_cnt` 0, `core_cfg_tvalid`=1 with CFG_DEFAULT, next accepted frame has `tlast` on beat 15.
